// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the two-player score keeper.
package scoreboard_pkg;

   localparam int DIGIT_W = 4;   // one BCD digit
   localparam int BIN_W   = 7;   // binary mirror of a 0..99 score

   typedef enum logic {
      PLAY      = 1'b0,
      GAME_OVER = 1'b1
   } state_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/score_keeper_bcd_updown_counter.sv
// Two-digit BCD up/down counter with a binary mirror used for comparisons.
// Saturates at 0 and MAX_SCORE; clr_i has priority. The caller guarantees
// inc_i and dec_i are never both high.
module bcd_updown_counter
   import scoreboard_pkg::*;
#(
   parameter int MAX_SCORE = 99
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               inc_i,
   input  logic               dec_i,
   input  logic               clr_i,
   output logic [DIGIT_W-1:0] tens_o,
   output logic [DIGIT_W-1:0] ones_o,
   output logic [BIN_W-1:0]   bin_o,
   output logic               changed_o
);

   localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_SCORE);

   logic [DIGIT_W-1:0] tens_q, tens_d, ones_q, ones_d;
   logic [BIN_W-1:0]   bin_q, bin_d;

   // Next score: clear, saturating increment with carry, saturating decrement with borrow.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      bin_d  = bin_q;
      if (clr_i) begin
         tens_d = '0;
         ones_d = '0;
         bin_d  = '0;
      end else if (inc_i && (bin_q < MAX_B)) begin
         bin_d = bin_q + 7'd1;
         if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end else if (dec_i && (bin_q != '0)) begin
         bin_d = bin_q - 7'd1;
         if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
         end else begin
            ones_d = ones_q - 4'd1;
         end
      end
   end

   // Score registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tens_q <= '0;
         ones_q <= '0;
         bin_q  <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
         bin_q  <= bin_d;
      end
   end

   assign tens_o    = tens_q;
   assign ones_o    = ones_q;
   assign bin_o     = bin_q;
   assign changed_o = (bin_d != bin_q);

endmodule

// File: rtl/score_keeper.sv
// Two-player score keeper: edge-detects button events, keeps BCD scores,
// and latches a winner under win-by-margin rules until a new game.
module score_keeper
   import scoreboard_pkg::*;
#(
   parameter int MAX_SCORE  = 99,
   parameter int WIN_SCORE  = 11,
   parameter int WIN_MARGIN = 2,
   parameter int ENABLE_WIN = 1
) (
   input  logic               clk_1khz,
   input  logic               rst_i,
   input  logic               p1_up_i,
   input  logic               p1_down_i,
   input  logic               p2_up_i,
   input  logic               p2_down_i,
   input  logic               new_game_i,
   output logic [DIGIT_W-1:0] p1_tens_o,
   output logic [DIGIT_W-1:0] p1_ones_o,
   output logic [DIGIT_W-1:0] p2_tens_o,
   output logic [DIGIT_W-1:0] p2_ones_o,
   output logic [1:0]         winner_o,
   output logic               game_over_o,
   output logic               score_changed_o
);

   localparam logic [BIN_W-1:0] WIN_B    = BIN_W'(WIN_SCORE);
   localparam logic [BIN_W-1:0] MARGIN_B = BIN_W'(WIN_MARGIN);

   // bit order: p1_up, p1_down, p2_up, p2_down, new_game
   logic [4:0]       in_vec, hist_q, rise;
   logic             ng, play;
   logic             p1_inc, p1_dec, p2_inc, p2_dec;
   logic             p1_chg, p2_chg;
   logic [BIN_W-1:0] p1_bin, p2_bin;
   logic             win1, win2;
   state_e           state_q, state_d;
   logic [1:0]       winner_q, winner_d;
   logic             changed_q;

   assign in_vec = {new_game_i, p2_down_i, p2_up_i, p1_down_i, p1_up_i};
   assign rise   = in_vec & ~hist_q;

   // One history flop per input for rising-edge detection.
   always_ff @(posedge clk_1khz) begin
      if (rst_i) hist_q <= '0;
      else       hist_q <= in_vec;
   end

   // Up is only honoured in PLAY; simultaneous up+down for one player cancels.
   assign ng     = rise[4];
   assign play   = (state_q == PLAY);
   assign p1_inc = rise[0] & ~rise[1] & play;
   assign p1_dec = rise[1] & ~rise[0];
   assign p2_inc = rise[2] & ~rise[3] & play;
   assign p2_dec = rise[3] & ~rise[2];

   bcd_updown_counter #(.MAX_SCORE(MAX_SCORE)) u_p1 (
      .clk_i(clk_1khz), .rst_i(rst_i), .inc_i(p1_inc), .dec_i(p1_dec), .clr_i(ng),
      .tens_o(p1_tens_o), .ones_o(p1_ones_o), .bin_o(p1_bin), .changed_o(p1_chg)
   );

   bcd_updown_counter #(.MAX_SCORE(MAX_SCORE)) u_p2 (
      .clk_i(clk_1khz), .rst_i(rst_i), .inc_i(p2_inc), .dec_i(p2_dec), .clr_i(ng),
      .tens_o(p2_tens_o), .ones_o(p2_ones_o), .bin_o(p2_bin), .changed_o(p2_chg)
   );

   // Win test on registered scores; the compare guards the unsigned subtraction.
   assign win1 = (p1_bin >= WIN_B) && (p1_bin >= p2_bin) && ((p1_bin - p2_bin) >= MARGIN_B);
   assign win2 = (p2_bin >= WIN_B) && (p2_bin >= p1_bin) && ((p2_bin - p1_bin) >= MARGIN_B);

   // Game FSM: enter GAME_OVER on a win, fall back to PLAY when a correction removes it.
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      if (ng || (ENABLE_WIN == 0)) begin
         state_d  = PLAY;
         winner_d = WIN_NONE;
      end else begin
         case (state_q)
            PLAY: begin
               if (win1) begin
                  state_d  = GAME_OVER;
                  winner_d = WIN_P1;
               end else if (win2) begin
                  state_d  = GAME_OVER;
                  winner_d = WIN_P2;
               end
            end
            GAME_OVER: begin
               if (win1) begin
                  winner_d = WIN_P1;
               end else if (win2) begin
                  winner_d = WIN_P2;
               end else begin
                  state_d  = PLAY;
                  winner_d = WIN_NONE;
               end
            end
            default: begin
               state_d  = PLAY;
               winner_d = WIN_NONE;
            end
         endcase
      end
   end

   // FSM state, winner and the score-changed pulse.
   always_ff @(posedge clk_1khz) begin
      if (rst_i) begin
         state_q   <= PLAY;
         winner_q  <= WIN_NONE;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         winner_q  <= winner_d;
         changed_q <= p1_chg | p2_chg;
      end
   end

   assign winner_o        = winner_q;
   assign game_over_o     = (state_q == GAME_OVER);
   assign score_changed_o = changed_q;

   // Margin >= 1 makes a double win impossible.
   a_no_double_win: assert property (@(posedge clk_1khz) disable iff (rst_i) winner_q != 2'b11);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench: stimulus pushes expected scores, monitor pops on each score_changed_o.
module tb_score_keeper;

   localparam logic [4:0] P1U = 5'b00001, P1D = 5'b00010, P2U = 5'b00100,
                          P2D = 5'b01000, NG  = 5'b10000;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ev, ev15;
   logic [3:0] p1t, p1o, p2t, p2o, a1t, a1o, a2t, a2o;
   logic [1:0] win, win15;
   logic       go, sc, go15, sc15;

   typedef struct { int p1; int p2; } exp_t;
   exp_t exp_q[$];
   int   nchk = 0, npass = 0;

   always #5 clk = ~clk;

   score_keeper dut (
      .clk_1khz(clk), .rst_i(rst),
      .p1_up_i(ev[0]), .p1_down_i(ev[1]), .p2_up_i(ev[2]), .p2_down_i(ev[3]), .new_game_i(ev[4]),
      .p1_tens_o(p1t), .p1_ones_o(p1o), .p2_tens_o(p2t), .p2_ones_o(p2o),
      .winner_o(win), .game_over_o(go), .score_changed_o(sc)
   );

   score_keeper #(.MAX_SCORE(15), .ENABLE_WIN(0)) dut15 (
      .clk_1khz(clk), .rst_i(rst),
      .p1_up_i(ev15[0]), .p1_down_i(ev15[1]), .p2_up_i(ev15[2]), .p2_down_i(ev15[3]), .new_game_i(ev15[4]),
      .p1_tens_o(a1t), .p1_ones_o(a1o), .p2_tens_o(a2t), .p2_ones_o(a2o),
      .winner_o(win15), .game_over_o(go15), .score_changed_o(sc15)
   );

   function automatic int bcd(input int v);
      return ((v / 10) << 4) | (v % 10);
   endfunction

   task automatic check(input string name, input int got, input int expv);
      nchk++;
      if (got == expv) npass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, expv, $time);
   endtask

   // Monitor: every score_changed_o pulse must match the oldest expected update.
   always @(negedge clk) begin
      if (!rst && sc) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_p1", {p1t, p1o}, bcd(e.p1));
            check("pulse_p2", {p2t, p2o}, bcd(e.p2));
         end
      end
   end

   // One-cycle event on the main DUT, then settle and check final state.
   task automatic fire(input logic [4:0] m, input int e1, input int e2, input bit chg, input int w);
      exp_t e;
      @(posedge clk); #1 ev = m;
      if (chg) begin e.p1 = e1; e.p2 = e2; exp_q.push_back(e); end
      @(posedge clk); #1 ev = '0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      check("no_missing_pulse", exp_q.size(), 0);
      check("p1_digits", {p1t, p1o}, bcd(e1));
      check("p2_digits", {p2t, p2o}, bcd(e2));
      check("winner", win, w);
      check("game_over", go, (w != 0) ? 1 : 0);
   endtask

   task automatic fire15(input logic [4:0] m, input int e1, input bit chg);
      @(posedge clk); #1 ev15 = m;
      @(posedge clk); @(negedge clk);
      check("sc15", sc15, chg);
      ev15 = '0;
      @(posedge clk); @(negedge clk);
      check("p1_digits15", {a1t, a1o}, bcd(e1));
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; ev = '0; ev15 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_p1", {p1t, p1o}, 0);
      check("rst_p2", {p2t, p2o}, 0);
      check("rst_winner", win, 0);
      check("rst_go", go, 0);
      check("rst_sc", sc, 0);
      check("rst_p1_15", {a1t, a1o}, 0);
      rst = 1'b0;

      // three single increments
      for (int i = 1; i <= 3; i++) fire(P1U, i, 0, 1, 0);

      // held input counts once
      @(posedge clk); #1 ev = P1U;
      e.p1 = 4; e.p2 = 0; exp_q.push_back(e);
      repeat (50) @(posedge clk);
      #1 ev = '0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      check("hold_no_missing", exp_q.size(), 0);
      check("hold_p1", {p1t, p1o}, bcd(4));

      fire(P1U | P1D, 4, 0, 0, 0);   // cancel
      fire(P1U | P2U, 5, 1, 1, 0);   // independent players
      fire(P2D, 5, 0, 1, 0);
      fire(P2D, 5, 0, 0, 0);         // floor at 0
      for (int i = 1; i <= 10; i++) fire(P2U, 5, i, 1, 0);  // carry 9 -> 10
      fire(P2D, 5, 9, 1, 0);         // borrow 10 -> 9
      fire(NG, 0, 0, 1, 0);

      // p1 wins 11/9
      for (int i = 1; i <= 9; i++) fire(P2U, 0, i, 1, 0);
      for (int i = 1; i <= 10; i++) fire(P1U, i, 9, 1, 0);
      @(posedge clk); #1 ev = P1U;
      e.p1 = 11; e.p2 = 9; exp_q.push_back(e);
      @(posedge clk); #1 ev = '0;
      @(negedge clk);
      check("go_at_n1", go, 0);
      @(posedge clk); @(negedge clk);
      check("go_at_n2", go, 1);
      check("winner_at_n2", win, 1);
      fire(P1U, 11, 9, 0, 1);        // up ignored in GAME_OVER
      fire(P1D, 10, 9, 1, 0);        // correction returns to PLAY

      // margin rule
      fire(P2U, 10, 10, 1, 0);
      fire(P1U, 11, 10, 1, 0);
      fire(P1U, 12, 10, 1, 1);
      fire(P2D, 12, 9, 1, 1);
      fire(P1D, 11, 9, 1, 1);
      fire(NG | P2U, 0, 0, 1, 0);    // new game overrides

      // p2 wins 0/11
      for (int i = 1; i <= 11; i++) fire(P2U, 0, i, 1, (i == 11) ? 2 : 0);

      // reset mid-game
      @(posedge clk); #1 ev = P2D; rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("midrst_p1", {p1t, p1o}, 0);
      check("midrst_p2", {p2t, p2o}, 0);
      check("midrst_winner", win, 0);
      check("midrst_go", go, 0);
      check("midrst_sc", sc, 0);
      ev = '0;
      @(posedge clk); #1 rst = 1'b0;

      // saturation at MAX_SCORE=15 with win logic disabled
      for (int i = 1; i <= 15; i++) fire15(P1U, i, 1);
      fire15(P1U, 15, 0);
      check("go15", go15, 0);
      check("win15", win15, 0);

      repeat (3) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
